// File: rtl/rv_fetch_unit_pkg.sv
// Shared constants and width helper for the instruction-fetch front end.
package rv_fetch_unit_pkg;

    localparam int          INST_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Counters must be able to hold the value DEPTH itself, not just DEPTH-1.
    function automatic int fetch_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO holding {pc, instr} entries for the fetch unit.
module fetch_fifo
    import rv_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    input  logic                          flush,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [fetch_cnt_w(DEPTH)-1:0] count
);

    localparam int CW = fetch_cnt_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
            rd_ptr_reg <= rd_ptr_reg + AW'(do_pop);
            count_reg  <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    // Head reads as zero when empty so decode never sees stale entries.
    assign rdata = empty ? '0 : mem[rd_ptr_reg];

    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/rv_fetch_unit.sv
// Decoupled fetch stage: PC ownership, credit-limited imem requests, prefetch FIFO, redirects.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHK_EN.
module rv_fetch_unit
    import rv_fetch_unit_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_misaligned
);

    localparam int CW = fetch_cnt_w(FIFO_DEPTH);
    localparam int EW = XLEN + 32;

    logic [XLEN-1:0] pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   drop_cnt_reg;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   live;
    logic [CW:0]     credit_sum;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [EW-1:0]   fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            halted;
    logic            accept;
    logic            rsp_fire;
    logic            push;
    logic            pop;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            misaligned_reg <= 1'b0;
        end else if (redirect_valid) begin
            misaligned_reg <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign target_pc        = redirect_pc;
    assign halted           = misaligned_reg;
    assign fetch_misaligned = misaligned_reg;
`else
    assign target_pc        = redirect_pc & ~XLEN'(INST_BYTES - 1);
    assign halted           = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    // Credits cover FIFO slots plus in-flight requests, so a push can never overflow.
    assign credit_sum     = {1'b0, fifo_count} + {1'b0, outstanding_reg};
    assign imem_req_valid = rst && !redirect_valid && !halted && !fifo_full
                            && (credit_sum < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_reg;
    assign accept         = imem_req_valid && imem_req_ready;

    // Responses with nothing tracked (memory not yet reset with us) are ignored.
    assign rsp_fire = imem_rsp_valid && (outstanding_reg != '0);

    // Live requests were issued back-to-back since the last redirect, so the
    // oldest one sits 4*live bytes behind the current pc.
    assign live   = outstanding_reg - drop_cnt_reg;
    assign rsp_pc = pc_reg - XLEN'(live) * XLEN'(INST_BYTES);

    assign push = rsp_fire && !redirect_valid && (drop_cnt_reg == '0);
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else if (redirect_valid) begin
            pc_reg          <= target_pc;
            outstanding_reg <= outstanding_reg - CW'(rsp_fire);
            drop_cnt_reg    <= outstanding_reg - CW'(rsp_fire);
        end else begin
            if (accept) begin
                pc_reg <= pc_reg + XLEN'(INST_BYTES);
            end
            outstanding_reg <= outstanding_reg + CW'(accept) - CW'(rsp_fire);
            if (rsp_fire && (drop_cnt_reg != '0)) begin
                drop_cnt_reg <= drop_cnt_reg - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({rsp_pc, imem_rsp_data}),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign inst_valid = !fifo_empty;
    assign inst_data  = fifo_head[31:0];
    assign inst_pc    = fifo_head[EW-1:32];

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Scoreboard bench for rv_fetch_unit: directed scenarios, in-order expected PC queue, memory model.
module tb_rv_fetch_unit;

    localparam logic [31:0] DMASK = 32'hC001_D00D;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_misaligned;

    int          tests_run;
    int          fails;
    int          pop_count;
    int          acc_count;
    int          base;
    logic        rsp_hold;
    logic [31:0] exp_q [$];
    logic [31:0] pend_q [$];

    rv_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_data        (inst_data),
        .inst_pc          (inst_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops one expected pc per instruction that decode actually consumes.
    task automatic monitor_loop();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && inst_valid && inst_ready && !redirect_valid) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL unexpected_pop: got pc %h, required no instruction", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] pop pc=%h data=%h", inst_pc, inst_data);
                    check("inst_pc", inst_pc, e);
                    check("inst_data", inst_data, e ^ DMASK);
                end
            end
        end
    endtask

    // In-order memory, one-cycle latency unless rsp_hold stalls it.
    task automatic memory_loop();
        forever begin
            @(posedge clk);
            if (!rst) begin
                pend_q.delete();
                acc_count = 0;
            end else if (imem_req_valid && imem_req_ready) begin
                pend_q.push_back(imem_req_addr);
                acc_count++;
            end
            @(negedge clk);
            if (rst && !rsp_hold && pend_q.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_q.pop_front() ^ DMASK;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rsp_hold       = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        tick();
        tick();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_data", inst_data, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_misaligned", fetch_misaligned, 0);
        exp_q.delete();
    endtask

    task automatic finish_test(input string name);
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        repeat (8) tick();
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_empty"}, inst_valid, 0);
    endtask

    initial begin
        tests_run      = 0;
        fails          = 0;
        pop_count      = 0;
        acc_count      = 0;
        rst            = 1'b0;
        rsp_hold       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        fork
            monitor_loop();
            memory_loop();
        join_none

        // Streaming from reset, 1-cycle memory, decode always ready.
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
        rst = 1'b1;
        #1;
        check("t1_first_req_valid", imem_req_valid, 1);
        check("t1_first_req_addr", imem_req_addr, 32'h0);
        tick();
        check("t1_no_bypass", inst_valid, 0);
        check("t1_second_addr", imem_req_addr, 32'h4);
        tick();
        check("t1_latency2", inst_valid, 1);
        base = pop_count;
        repeat (5) tick();
        check("t1_throughput", pop_count - base, 5);
        repeat (3) tick();
        finish_test("t1");

        // Decode stalled: credit limit holds issue at four requests.
        do_reset();
        imem_req_ready = 1'b1;
        for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
        rst = 1'b1;
        repeat (8) tick();
        check("t2_accepts", acc_count, 4);
        check("t2_req_blocked", imem_req_valid, 0);
        check("t2_head_valid", inst_valid, 1);
        check("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        repeat (4) tick();
        finish_test("t2");

        // Redirect with three outstanding, one response in the redirect cycle.
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        rsp_hold       = 1'b1;
        rst            = 1'b1;
        repeat (3) tick();
        check("t3_outstanding", acc_count, 3);
        imem_req_ready = 1'b0;
        rsp_hold       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("t3_no_req_in_redirect", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("t3_inst_valid_after", inst_valid, 0);
        check("t3_req_valid_after", imem_req_valid, 1);
        check("t3_req_addr_after", imem_req_addr, 32'h100);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        repeat (3) tick();
        finish_test("t3");

        // Back-to-back redirects: only the 0x300 stream survives.
        do_reset();
        imem_req_ready = 1'b1;
        rsp_hold       = 1'b1;
        rst            = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        rsp_hold       = 1'b0;
        inst_ready     = 1'b1;
        #1;
        check("t4_req_valid", imem_req_valid, 1);
        check("t4_req_addr", imem_req_addr, 32'h300);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        exp_q.push_back(32'h308);
        repeat (3) tick();
        finish_test("t4");

        // PC wraps from the top of the address space.
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        rst            = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        tick();
        check("t5_wrap_addr", imem_req_addr, 32'h0);
        tick();
        finish_test("t5");

        // Misaligned redirect target.
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        rst            = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_CHK_EN
        check("t6_flag_set", fetch_misaligned, 1);
        check("t6_halted", imem_req_valid, 0);
        repeat (3) tick();
        check("t6_still_halted", imem_req_valid, 0);
        check("t6_no_accepts", acc_count, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h104;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t6_flag_clear", fetch_misaligned, 0);
        check("t6_resume_valid", imem_req_valid, 1);
        check("t6_resume_addr", imem_req_addr, 32'h104);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
`else
        check("t6_flag_tied", fetch_misaligned, 0);
        check("t6_req_valid", imem_req_valid, 1);
        check("t6_forced_align", imem_req_addr, 32'h100);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
`endif
        repeat (2) tick();
        finish_test("t6");

        // Reset while the FIFO holds entries and a request is in flight.
        do_reset();
        imem_req_ready = 1'b1;
        rst            = 1'b1;
        repeat (3) tick();
        check("t7_prefill", inst_valid, 1);
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        rst = 1'b1;
        repeat (2) tick();
        finish_test("t7");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/rv_fetch_unit.md
# rv_fetch_unit

Parametrised instruction-fetch front end that replaces the single-cycle PC register, PC+4 adder and next-PC mux with a decoupled fetch stage. It owns the PC, issues pipelined requests to a variable-latency instruction memory, buffers returned instructions in a small prefetch FIFO, and accepts redirects from the branch/jump resolution logic. Its output feeds decode through a valid/ready handshake, which lets the datapath stall without losing fetched instructions.

## Interface
Parameters:
- XLEN, 32, PC and address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2; also the cap on in-flight requests.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets at the clock edge).
- imem_req_valid  out  1  fetch request present.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  byte address of request, [1:0]=00.
- imem_rsp_valid  in  1  instruction returned; in order; never before the cycle after acceptance.
- imem_rsp_data  in  32  returned instruction word.
- redirect_valid  in  1  one-cycle pulse: taken branch, jump or jalr.
- redirect_pc  in  XLEN  new fetch target.
- inst_valid  out  1  FIFO head is valid.
- inst_ready  in  1  decode consumes head.
- inst_data  out  32  instruction at FIFO head.
- inst_pc  out  XLEN  PC of inst_data.
- fetch_misaligned  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- State: pc, FIFO {instr, pc}, occupancy cnt, outstanding, drop_cnt. All counters are $clog2(FIFO_DEPTH)+1 bits wide.
- Issue: imem_req_valid = rst & !redirect_valid & !halted & (cnt + outstanding < FIFO_DEPTH). imem_req_addr = pc. On valid&ready: pc += 4 (mod 2^XLEN; wraps silently), outstanding++.
- Response: always accepted. On rsp: outstanding--. If drop_cnt>0, drop_cnt-- and the data is discarded. Otherwise push {imem_rsp_data, pc of that request} into the FIFO. A parallel in-order PC queue, or an issued-minus-outstanding reconstruction, supplies the pc of the request.
- The credit rule guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- Pop: on inst_valid & inst_ready & !redirect_valid, advance the head. Push and pop may occur in the same cycle (cnt unchanged).
- Redirect (has priority over everything else):
  - FIFO flushes (cnt=0) and pc is set to redirect_pc.
  - Any response arriving in the same cycle is discarded.
  - drop_cnt becomes outstanding − imem_rsp_valid, with outstanding unchanged except for that response.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins, and drops accumulate correctly.
- Reset mid-operation: all state clears. Responses arriving after reset are not tracked; the memory is reset alongside this unit.

## Timing
- Reset values: imem_req_valid=0 while rst=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, fetch_misaligned=0. Counters are 0.
- The first request is asserted in the first cycle with rst=1.
- There is no bypass: a response pushed at edge N makes inst_valid high after edge N. Minimum latency from request acceptance to inst_valid is 2 cycles.
- After a redirect at edge N, imem_req_valid may assert in cycle N+1 with addr=redirect_pc. inst_valid is 0 in cycle N+1.
- With ready held high and 1-cycle memory latency, sustained throughput is 1 instruction/cycle.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - A redirect with redirect_pc[1:0]≠0 sets fetch_misaligned=1 and halts request issue.
  - Outstanding responses are still drained and dropped.
  - The next aligned redirect clears the flag and resumes fetch.
- Not defined: fetch_misaligned is tied to 0, and redirect_pc[1:0] is forced to 00.

## Structure
- Shared defines/package holds INST_BYTES=4, the default RESET_PC, and FETCH_CNT_W(depth) as the width helper for the counters.
- One sub-module: fetch_fifo, a synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/flush, and full/empty/count outputs. It stores {pc, instr}.

## Test plan
- Reset release, 1-cycle memory, inst_ready=1 → requests at 0x0, 0x4, 0x8…; first inst_valid 2 cycles after first accept; 1 instr/cycle thereafter.
- inst_ready=0, FIFO_DEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0. Raising ready restores issue with no instruction lost or duplicated.
- 3 outstanding requests, then redirect_valid to 0x100 coinciding with one response → that response and the next 2 are dropped; first inst_pc=0x100.
- Two redirects on consecutive cycles (0x200, then 0x300) → only 0x300-stream instructions appear.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x102 → fetch_misaligned=1, no requests issued. Redirect to 0x104 → flag clears, fetch resumes at 0x104.
- pc=0xFFFF_FFFC with RESET_PC set accordingly → next request address is 0x0000_0000.
